rv_decode_stage: RTL

Parametrised, registered RISC-V RV32I/RV64I instruction decode stage. It sits between fetch and execute. Each cycle it accepts one fetched instruction plus its PC over a valid/ready handshake. It decodes the opcode class, register addresses, funct fields and the sign-extended immediate, flags illegal encodings, and presents the result one cycle later. A 2-entry skid buffer keeps full throughput under backpressure.

---
 rtl/rv_pkg.sv | 69 ++++++
 rtl/rv_imm_gen.sv | 44 ++++
 rtl/rv_decode_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared RV32I/RV64I decode types, opcodes and field positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam int c_xlen_max = 64;

    typedef enum logic [3:0] {
        OP_ALU_R   = 4'd0,
        OP_ALU_I   = 4'd1,
        OP_LOAD    = 4'd2,
        OP_STORE   = 4'd3,
        OP_BRANCH  = 4'd4,
        OP_JAL     = 4'd5,
        OP_JALR    = 4'd6,
        OP_LUI     = 4'd7,
        OP_AUIPC   = 4'd8,
        OP_FENCE   = 4'd9,
        OP_ECALL   = 4'd10,
        OP_EBREAK  = 4'd11,
        OP_ILLEGAL = 4'd12
    } t_op_class;

    localparam logic [6:0] c_opc_alu_r  = 7'b0110011;
    localparam logic [6:0] c_opc_alu_i  = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_fence  = 7'b0001111;
    localparam logic [6:0] c_opc_system = 7'b1110011;

    localparam int c_rd_lsb     = 7;
    localparam int c_rd_msb     = 11;
    localparam int c_funct3_lsb = 12;
    localparam int c_funct3_msb = 14;
    localparam int c_rs1_lsb    = 15;
    localparam int c_rs1_msb    = 19;
    localparam int c_rs2_lsb    = 20;
    localparam int c_rs2_msb    = 24;
    localparam int c_funct7_lsb = 25;
    localparam int c_funct7_msb = 31;

    // imm/pc are sized for the widest datapath; narrower builds use the low bits
    typedef struct packed {
        t_op_class               op_class;
        logic [4:0]              rd;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [2:0]              funct3;
        logic [6:0]              funct7;
        logic [c_xlen_max-1:0]   imm;
        logic [c_xlen_max-1:0]   pc;
        logic                    illegal;
    } t_decoded;

    localparam t_decoded c_dec_reset = '{OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                                         {c_xlen_max{1'b0}}, {c_xlen_max{1'b0}}, 1'b0};

endpackage

`default_nettype wire

// File: rtl/rv_imm_gen.sv
// ============================================================================
// Module      : rv_imm_gen
// Description : Selects the I/S/B/U/J immediate by class, sign-extended to XLEN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  t_op_class       op_class,
    output logic [XLEN-1:0] imm
);

    logic [31:0] w_imm32;
    logic        w_unused_opc;

    always_comb begin
        w_imm32 = 32'd0;
        case (op_class)
            OP_ALU_I, OP_LOAD, OP_JALR, OP_ECALL, OP_EBREAK:
                w_imm32 = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                w_imm32 = {instr[31:12], 12'b0};
            OP_JAL:
                w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                w_imm32 = 32'd0;
        endcase
    end

    assign imm          = XLEN'($signed(w_imm32));
    assign w_unused_opc = ^instr[6:0];

endmodule

`default_nettype wire

// File: rtl/rv_decode_stage.sv
// ============================================================================
// Module      : rv_decode_stage
// Description : Registered RV32I/RV64I decode with output + skid register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output t_op_class       out_class,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    t_op_class       w_class;
    logic            w_sys_ok;
    logic [XLEN-1:0] w_imm;
    t_decoded        w_dec;
    logic            w_accept;
    logic            w_fire;

    t_decoded        r_or;
    t_decoded        r_sk;
    logic            r_or_valid;
    logic            r_sk_valid;

    assign w_sys_ok = (in_instr[31:21] == 11'd0)
                   && (in_instr[c_rs1_msb:c_rs1_lsb] == 5'd0)
                   && (in_instr[c_funct3_msb:c_funct3_lsb] == 3'd0)
                   && (in_instr[c_rd_msb:c_rd_lsb] == 5'd0);

    // Every legal opcode ends in 2'b11, so a bad low pair falls to the default
    always_comb begin
        w_class = OP_ILLEGAL;
        case (in_instr[6:0])
            c_opc_alu_r:  w_class = OP_ALU_R;
            c_opc_alu_i:  w_class = OP_ALU_I;
            c_opc_load:   w_class = OP_LOAD;
            c_opc_store:  w_class = OP_STORE;
            c_opc_branch: w_class = OP_BRANCH;
            c_opc_jal:    w_class = OP_JAL;
            c_opc_jalr:   w_class = (in_instr[c_funct3_msb:c_funct3_lsb] == 3'd0) ? OP_JALR : OP_ILLEGAL;
            c_opc_lui:    w_class = OP_LUI;
            c_opc_auipc:  w_class = OP_AUIPC;
            c_opc_fence:  w_class = OP_FENCE;
            c_opc_system: w_class = !w_sys_ok ? OP_ILLEGAL : (in_instr[20] ? OP_EBREAK : OP_ECALL);
            default:      w_class = OP_ILLEGAL;
        endcase
    end

    rv_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr    (in_instr),
        .op_class (w_class),
        .imm      (w_imm)
    );

    always_comb begin
        w_dec          = c_dec_reset;
        w_dec.op_class = w_class;
        w_dec.rd       = in_instr[c_rd_msb:c_rd_lsb];
        w_dec.rs1      = in_instr[c_rs1_msb:c_rs1_lsb];
        w_dec.rs2      = in_instr[c_rs2_msb:c_rs2_lsb];
        w_dec.funct3   = in_instr[c_funct3_msb:c_funct3_lsb];
        w_dec.funct7   = in_instr[c_funct7_msb:c_funct7_lsb];
        w_dec.imm      = c_xlen_max'($signed(w_imm));
        w_dec.pc       = c_xlen_max'(in_pc);
        w_dec.illegal  = (w_class == OP_ILLEGAL);
    end

    assign in_ready = !r_sk_valid;
    assign w_accept = in_valid && !r_sk_valid;
    assign w_fire   = r_or_valid && out_ready;

    // SK only fills while OR is stalled, and drains into OR before any new word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_or_valid <= 1'b0;
            r_sk_valid <= 1'b0;
            r_or       <= c_dec_reset;
            r_sk       <= c_dec_reset;
        end else if (flush) begin
            r_or_valid <= 1'b0;
            r_sk_valid <= 1'b0;
        end else if (w_fire) begin
            if (r_sk_valid) begin
                r_or       <= r_sk;
                r_sk_valid <= 1'b0;
            end else if (w_accept) begin
                r_or       <= w_dec;
            end else begin
                r_or_valid <= 1'b0;
            end
        end else if (r_or_valid) begin
            if (w_accept) begin
                r_sk       <= w_dec;
                r_sk_valid <= 1'b1;
            end
        end else if (w_accept) begin
            r_or       <= w_dec;
            r_or_valid <= 1'b1;
        end
    end

    assign out_valid   = r_or_valid;
    assign out_class   = r_or.op_class;
    assign out_rd      = r_or.rd;
    assign out_rs1     = r_or.rs1;
    assign out_rs2     = r_or.rs2;
    assign out_funct3  = r_or.funct3;
    assign out_funct7  = r_or.funct7;
    assign out_imm     = r_or.imm[XLEN-1:0];
    assign out_pc      = r_or.pc[XLEN-1:0];
    assign out_illegal = r_or.illegal;

    generate
        if (XLEN < c_xlen_max) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^{r_or.imm[c_xlen_max-1:XLEN], r_or.pc[c_xlen_max-1:XLEN]};
        end
    endgenerate

endmodule

`default_nettype wire
